// File: rtl/mem_port_arbiter_if.sv
// Shared memory port bundle between mem_port_arbiter and the memory.
//   master : arbiter side (drives request fields, samples ready/response)
//   slave  : memory side (drives ready, response valid and read data)
// Signals:
//   mem_valid/mem_ready       request handshake
//   mem_addr/wen/wdata/wmask  latched request fields
//   mem_rsp_valid/mem_rdata   response (read data or write ack)
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int MASK_W = DATA_W / 8;

    logic              mem_valid;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_wen;
    logic [DATA_W-1:0] mem_wdata;
    logic [MASK_W-1:0] mem_wmask;
    logic              mem_rsp_valid;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
        input  mem_ready, mem_rsp_valid, mem_rdata
    );

    modport slave (
        input  mem_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
        output mem_ready, mem_rsp_valid, mem_rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter/sequencer sharing one memory port among NR_REQ
// requesters. One request is accepted at a time, its fields are latched
// and driven onto the shared port, and the response is routed back to the
// granted requester.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   req_valid/ready  per-requester request handshake (ready one-hot or 0)
//   req_addr/wen/wdata/wmask  packed per-requester request fields
//   rsp_valid        per-requester response pulse
//   rsp_rdata        response data, broadcast
//   mem              shared memory port (master side)
//   grant_idx        current/last granted requester
//   busy             high while a transaction is in flight
module mem_port_arbiter #(
    parameter int NR_REQ = 2,
    parameter int IDX_W  = $clog2(NR_REQ),
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NR_REQ-1:0]             req_valid,
    output logic [NR_REQ-1:0]             req_ready,
    input  logic [NR_REQ*ADDR_W-1:0]      req_addr,
    input  logic [NR_REQ-1:0]             req_wen,
    input  logic [NR_REQ*DATA_W-1:0]      req_wdata,
    input  logic [NR_REQ*(DATA_W/8)-1:0]  req_wmask,
    output logic [NR_REQ-1:0]             rsp_valid,
    output logic [DATA_W-1:0]             rsp_rdata,
    mem_port_arbiter_if.master            mem,
    output logic [IDX_W-1:0]              grant_idx,
    output logic                          busy
);
    localparam int MASK_W = DATA_W / 8;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              wen;
        logic [DATA_W-1:0] wdata;
        logic [MASK_W-1:0] wmask;
    } req_t;

    state_t           state_q, state_d;
    req_t             lane_req [NR_REQ];
    req_t             lat_q;
    logic             mem_valid_q;
    logic [IDX_W-1:0] last_grant;
    logic [IDX_W-1:0] winner;
    logic             any_valid;
    logic             load;
    logic             done;

    // Unpack the flat request buses into one struct per requester.
    genvar n;
    generate
        for (n = 0; n < NR_REQ; n++) begin : g_lane
            assign lane_req[n] = {req_addr[n*ADDR_W +: ADDR_W], req_wen[n],
                                  req_wdata[n*DATA_W +: DATA_W],
                                  req_wmask[n*MASK_W +: MASK_W]};
        end
    endgenerate

    // Search upward from last_grant+1, wrapping at NR_REQ (not 2**IDX_W),
    // so out-of-range indices are never candidates. The sum is one bit
    // wider than the index since it can reach 2*NR_REQ-1 before the wrap.
    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] cand;
    always_comb begin
        winner    = '0;
        any_valid = 1'b0;
        sum       = '0;
        cand      = '0;
        for (int k = 1; k <= NR_REQ; k++) begin
            sum = {1'b0, last_grant} + (IDX_W+1)'(k);
            if (sum >= (IDX_W+1)'(NR_REQ))
                sum = sum - (IDX_W+1)'(NR_REQ);
            cand = sum[IDX_W-1:0];
            if (!any_valid && req_valid[cand]) begin
                any_valid = 1'b1;
                winner    = cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        rsp_valid = '0;
        load      = 1'b0;
        done      = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_valid) begin
                    req_ready[winner] = 1'b1;
                    load              = 1'b1;
                    state_d           = ISSUE;
                end
            end
            ISSUE: begin
                if (mem.mem_ready) state_d = WAIT;
            end
            WAIT: begin
                if (mem.mem_rsp_valid) begin
                    rsp_valid[grant_idx] = 1'b1;
                    done                 = 1'b1;
                    state_d              = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // last_grant only advances on completion, so an abandoned (reset)
    // transaction does not count as served.
    always_ff @(posedge clk) begin
        if (rst) begin
            lat_q       <= '0;
            mem_valid_q <= 1'b0;
            grant_idx   <= '0;
            last_grant  <= IDX_W'(NR_REQ - 1);
        end else begin
            if (load) begin
                lat_q       <= lane_req[winner];
                grant_idx   <= winner;
                mem_valid_q <= 1'b1;
            end else if (state_q == ISSUE && mem.mem_ready) begin
                mem_valid_q <= 1'b0;
            end
            if (done) last_grant <= grant_idx;
        end
    end

    assign mem.mem_valid = mem_valid_q;
    assign mem.mem_addr  = lat_q.addr;
    assign mem.mem_wen   = lat_q.wen;
    assign mem.mem_wdata = lat_q.wdata;
    assign mem.mem_wmask = lat_q.wmask;
    assign rsp_rdata     = mem.mem_rdata;
    assign busy          = (state_q != IDLE);
endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    int n_chk  = 0;
    int n_fail = 0;

    // ---------------- DUT A: two requesters ----------------
    logic [1:0]  a_valid, a_ready, a_wen, a_rsp;
    logic [63:0] a_addr, a_wdata;
    logic [7:0]  a_wmask;
    logic [31:0] a_rdata;
    logic [0:0]  a_gidx;
    logic        a_busy;
    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) ma();

    mem_port_arbiter #(.NR_REQ(2), .ADDR_W(32), .DATA_W(32)) dut_a (
        .clk(clk), .rst(rst),
        .req_valid(a_valid), .req_ready(a_ready), .req_addr(a_addr),
        .req_wen(a_wen), .req_wdata(a_wdata), .req_wmask(a_wmask),
        .rsp_valid(a_rsp), .rsp_rdata(a_rdata), .mem(ma),
        .grant_idx(a_gidx), .busy(a_busy)
    );

    // ---------------- DUT B: three requesters ----------------
    logic [2:0]  b_valid, b_ready, b_wen, b_rsp;
    logic [95:0] b_addr, b_wdata;
    logic [11:0] b_wmask;
    logic [31:0] b_rdata;
    logic [1:0]  b_gidx;
    logic        b_busy;
    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) mb();

    mem_port_arbiter #(.NR_REQ(3), .ADDR_W(32), .DATA_W(32)) dut_b (
        .clk(clk), .rst(rst),
        .req_valid(b_valid), .req_ready(b_ready), .req_addr(b_addr),
        .req_wen(b_wen), .req_wdata(b_wdata), .req_wmask(b_wmask),
        .rsp_valid(b_rsp), .rsp_rdata(b_rdata), .mem(mb),
        .grant_idx(b_gidx), .busy(b_busy)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // ---------------- table-driven single transactions on A ----------------
    // Fields in the record belong to the expected winner; the other requester
    // carries the bitwise inverse so wrong steering is visible.
    typedef struct {
        logic [1:0]  valid;
        logic        wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        logic [31:0] rdata;
        int          rdy_dly;
        int          rsp_dly;
        int          exp_g;
    } vec_t;

    vec_t tbl [7];

    task automatic a_set(input vec_t v);
        for (int n = 0; n < 2; n++) begin
            bit w;
            w = (n == v.exp_g);
            a_addr[n*32 +: 32]  = w ? v.addr  : ~v.addr;
            a_wdata[n*32 +: 32] = w ? v.wdata : ~v.wdata;
            a_wmask[n*4 +: 4]   = w ? v.wmask : ~v.wmask;
            a_wen[n]            = w ? v.wen   : ~v.wen;
        end
        a_valid = v.valid;
    endtask

    task automatic a_txn(input vec_t v);
        a_set(v);
        #1;
        check("a_ready_accept", a_ready, 64'(1) << v.exp_g);
        check("a_busy_idle", a_busy, 0);
        cyc();
        a_valid[v.exp_g] = 1'b0;
        #1;
        check("a_mem_valid", ma.mem_valid, 1);
        check("a_mem_addr", ma.mem_addr, v.addr);
        check("a_mem_wen", ma.mem_wen, v.wen);
        check("a_mem_wdata", ma.mem_wdata, v.wdata);
        check("a_mem_wmask", ma.mem_wmask, v.wmask);
        check("a_grant_idx", a_gidx, v.exp_g);
        check("a_busy_issue", a_busy, 1);
        check("a_ready_issue", a_ready, 0);
        for (int i = 0; i < v.rdy_dly; i++) begin
            ma.mem_rsp_valid = (i == 1);
            #1;
            check("a_rsp_in_issue", a_rsp, 0);
            cyc();
            ma.mem_rsp_valid = 1'b0;
            #1;
            check("a_bp_valid", ma.mem_valid, 1);
            check("a_bp_addr", ma.mem_addr, v.addr);
            check("a_bp_wmask", ma.mem_wmask, v.wmask);
            check("a_bp_ready", a_ready, 0);
        end
        ma.mem_ready = 1'b1;
        cyc();
        ma.mem_ready = 1'b0;
        #1;
        check("a_mem_valid_wait", ma.mem_valid, 0);
        check("a_busy_wait", a_busy, 1);
        for (int i = 0; i < v.rsp_dly; i++) begin
            cyc();
            check("a_rsp_early", a_rsp, 0);
        end
        ma.mem_rsp_valid = 1'b1;
        ma.mem_rdata     = v.rdata;
        #1;
        check("a_rsp_valid", a_rsp, 64'(1) << v.exp_g);
        check("a_rsp_rdata", a_rdata, v.rdata);
        cyc();
        ma.mem_rsp_valid = 1'b0;
        #1;
        check("a_rsp_pulse_end", a_rsp, 0);
        check("a_busy_done", a_busy, 0);
        check("a_grant_hold", a_gidx, v.exp_g);
    endtask

    // ---------------- B: transaction-level reference model ----------------
    logic [31:0] bm_addr [3];
    logic [31:0] bm_wdata [3];
    logic [3:0]  bm_wmask [3];
    logic        bm_wen [3];
    int          b_last = 2;
    int          wait_cnt [3];

    task automatic b_drive();
        for (int n = 0; n < 3; n++) begin
            b_addr[n*32 +: 32]  = bm_addr[n];
            b_wdata[n*32 +: 32] = bm_wdata[n];
            b_wmask[n*4 +: 4]   = bm_wmask[n];
            b_wen[n]            = bm_wen[n];
        end
    endtask

    task automatic b_newfields(input int n);
        bm_addr[n]  = $urandom;
        bm_wdata[n] = $urandom;
        bm_wmask[n] = 4'($urandom_range(0, 15));
        bm_wen[n]   = 1'($urandom_range(0, 1));
    endtask

    task automatic b_txn(input int rdy_dly, input int rsp_dly, output int g);
        int e;
        logic [31:0] rd;
        e = -1;
        for (int k = 1; k <= 3; k++) begin
            int i;
            i = (b_last + k) % 3;
            if (e < 0 && b_valid[i]) e = i;
        end
        b_drive();
        #1;
        check("b_ready", b_ready, 64'(1) << e);
        cyc();
        b_valid[e] = 1'b0;
        #1;
        check("b_mem_valid", mb.mem_valid, 1);
        check("b_mem_addr", mb.mem_addr, bm_addr[e]);
        check("b_mem_wen", mb.mem_wen, bm_wen[e]);
        check("b_mem_wdata", mb.mem_wdata, bm_wdata[e]);
        check("b_mem_wmask", mb.mem_wmask, bm_wmask[e]);
        check("b_grant_idx", b_gidx, e);
        for (int i = 0; i < rdy_dly; i++) begin
            mb.mem_rsp_valid = 1'($urandom_range(0, 1));
            #1;
            check("b_rsp_in_issue", b_rsp, 0);
            check("b_ready_issue", b_ready, 0);
            cyc();
            mb.mem_rsp_valid = 1'b0;
        end
        mb.mem_ready = 1'b1;
        cyc();
        mb.mem_ready = 1'b0;
        for (int i = 0; i < rsp_dly; i++) begin
            #1;
            check("b_rsp_early", b_rsp, 0);
            cyc();
        end
        rd = $urandom;
        mb.mem_rsp_valid = 1'b1;
        mb.mem_rdata     = rd;
        #1;
        check("b_rsp_valid", b_rsp, 64'(1) << e);
        check("b_rsp_rdata", b_rdata, rd);
        cyc();
        mb.mem_rsp_valid = 1'b0;
        #1;
        check("b_busy_done", b_busy, 0);
        for (int i = 0; i < 3; i++) begin
            if (i == e) wait_cnt[i] = 0;
            else if (b_valid[i]) begin
                wait_cnt[i]++;
                check("b_fairness", wait_cnt[i] < 3, 1);
            end
        end
        b_last = e;
        g = e;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int g;
        int seq [4];
        a_valid = '0; a_addr = '0; a_wen = '0; a_wdata = '0; a_wmask = '0;
        b_valid = '0; b_addr = '0; b_wen = '0; b_wdata = '0; b_wmask = '0;
        ma.mem_ready = 1'b0; ma.mem_rsp_valid = 1'b0; ma.mem_rdata = '0;
        mb.mem_ready = 1'b0; mb.mem_rsp_valid = 1'b0; mb.mem_rdata = '0;
        for (int i = 0; i < 3; i++) begin
            b_newfields(i);
            wait_cnt[i] = 0;
        end

        //            valid  wen   addr          wdata         wmask rdata         rdy rsp g
        tbl[0] = '{2'b01, 1'b0, 32'h8000_0000, 32'h0000_0000, 4'h0, 32'hDEAD_BEEF, 0, 0, 0};
        tbl[1] = '{2'b11, 1'b0, 32'h8000_0100, 32'h0000_0000, 4'h0, 32'h1111_2222, 0, 0, 1};
        tbl[2] = '{2'b11, 1'b0, 32'h8000_0200, 32'h0000_0000, 4'h0, 32'h3333_4444, 0, 0, 0};
        tbl[3] = '{2'b11, 1'b1, 32'h8000_0300, 32'hA5A5_5A5A, 4'hF, 32'h0000_0000, 0, 1, 1};
        tbl[4] = '{2'b10, 1'b1, 32'h8000_0010, 32'h1234_5678, 4'h3, 32'h0000_0000, 0, 0, 1};
        tbl[5] = '{2'b01, 1'b0, 32'h8000_0400, 32'h0000_0000, 4'hC, 32'hCAFE_F00D, 5, 0, 0};
        tbl[6] = '{2'b11, 1'b0, 32'h8000_0500, 32'h0000_0000, 4'h0, 32'h5555_6666, 2, 2, 1};

        rst = 1'b1;
        cyc(); cyc();
        rst = 1'b0;
        #1;
        check("rst_busy", a_busy, 0);
        check("rst_mem_valid", ma.mem_valid, 0);
        check("rst_mem_addr", ma.mem_addr, 0);
        check("rst_mem_wen", ma.mem_wen, 0);
        check("rst_mem_wdata", ma.mem_wdata, 0);
        check("rst_mem_wmask", ma.mem_wmask, 0);
        check("rst_grant_idx", a_gidx, 0);
        check("rst_req_ready", a_ready, 0);
        check("rst_rsp_valid", a_rsp, 0);

        // Stray response in IDLE must be ignored.
        ma.mem_rsp_valid = 1'b1;
        #1;
        check("idle_rsp_ignored", a_rsp, 0);
        cyc();
        ma.mem_rsp_valid = 1'b0;
        #1;
        check("idle_stays", a_busy, 0);

        for (int i = 0; i < 7; i++) a_txn(tbl[i]);

        // Reset in WAIT: complete a grant-0 transaction, then abandon a
        // grant-1 one; the next grant must still be requester 0.
        a_txn('{2'b01, 1'b0, 32'h8000_0600, 32'h0, 4'h0, 32'h0, 0, 0, 0});
        a_set('{2'b11, 1'b0, 32'h8000_0700, 32'h0, 4'h0, 32'h0, 0, 0, 1});
        #1;
        check("r5_ready", a_ready, 2'b10);
        cyc();
        a_valid = '0;
        ma.mem_ready = 1'b1;
        cyc();
        ma.mem_ready = 1'b0;
        #1;
        check("r5_in_wait", a_busy, 1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        #1;
        check("r5_busy", a_busy, 0);
        check("r5_mem_valid", ma.mem_valid, 0);
        check("r5_grant_idx", a_gidx, 0);
        check("r5_mem_addr", ma.mem_addr, 0);
        ma.mem_rsp_valid = 1'b1;
        #1;
        check("r5_late_rsp", a_rsp, 0);
        cyc();
        ma.mem_rsp_valid = 1'b0;
        #1;
        check("r5_idle", a_busy, 0);
        a_valid = 2'b11;
        #1;
        check("r5_first_grant", a_ready, 2'b01);
        a_valid = '0;
        #1;

        // Reset also returned B to its initial pointer.
        b_last = 2;

        // NR_REQ=3 fairness with requester 1 idle.
        b_valid = 3'b101;
        for (int t = 0; t < 4; t++) begin
            b_txn(0, 0, g);
            seq[t] = g;
            b_valid[g] = 1'b1;
            b_newfields(g);
        end
        for (int t = 0; t < 4; t++)
            check("b_fair_seq", seq[t], (t % 2 == 0) ? 0 : 2);
        b_valid = '0;

        // Randomised traffic on B against the model.
        for (int it = 0; it < 300; it++) begin
            for (int n = 0; n < 3; n++) begin
                if (!b_valid[n] && $urandom_range(0, 1) == 1) begin
                    b_newfields(n);
                    b_valid[n] = 1'b1;
                    wait_cnt[n] = 0;
                end
            end
            if (b_valid == 3'b000) begin
                mb.mem_rsp_valid = 1'($urandom_range(0, 1));
                b_drive();
                #1;
                check("b_idle_ready", b_ready, 0);
                check("b_idle_rsp", b_rsp, 0);
                cyc();
                mb.mem_rsp_valid = 1'b0;
                #1;
                check("b_idle_busy", b_busy, 0);
            end else begin
                b_txn($urandom_range(0, 3), $urandom_range(0, 3), g);
                check("b_grant_range", g < 3, 1);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Round-robin arbiter and sequencer that shares one memory port among NR_REQ requesters, for example IFU and LSU sharing the data/instruction memory in the npc core. It accepts one request at a time and latches its fields. It then drives the shared port through a request/response handshake and routes the response back to the granted requester. It is the control side of the one-hot key/data steering that the generic mux library performs combinationally.

Parameters:
NR_REQ, 2, number of requesters (>=2, need not be a power of two)
IDX_W, 1, grant index width, equal to clog2(NR_REQ)
ADDR_W, 32, address width
DATA_W, 32, data width (multiple of 8); mask width is DATA_W/8

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
req_valid  in  NR_REQ  per-requester request valid
req_ready  out  NR_REQ  per-requester accept, one-hot or zero
req_addr  in  NR_REQ*ADDR_W  packed addresses; requester n at [ADDR_W*(n+1)-1 : ADDR_W*n]
req_wen  in  NR_REQ  1 = write, 0 = read
req_wdata  in  NR_REQ*DATA_W  packed write data
req_wmask  in  NR_REQ*DATA_W/8  packed byte masks
rsp_valid  out  NR_REQ  per-requester response pulse
rsp_rdata  out  DATA_W  response data, broadcast to all requesters
mem_valid  out  1  shared-port request valid
mem_ready  in  1  memory accepts request
mem_addr  out  ADDR_W  latched address
mem_wen  out  1  latched write enable
mem_wdata  out  DATA_W  latched write data
mem_wmask  out  DATA_W/8  latched mask
mem_rsp_valid  in  1  memory response (read data or write ack)
mem_rdata  in  DATA_W  memory read data
grant_idx  out  IDX_W  index of current/last granted requester
busy  out  1  high when state is not IDLE

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- State machine states are IDLE, ISSUE and WAIT.
- Reset values:
  - state = IDLE.
  - mem_valid, mem_wen, mem_addr, mem_wdata, mem_wmask = 0.
  - grant_idx = 0.
  - Internal last_grant = NR_REQ-1, so requester 0 wins first.
  - req_ready = 0, rsp_valid = 0, busy = 0.
- Winner selection (combinational, in IDLE only):
  - Search order is (last_grant+1) mod NR_REQ, then upward, wrapping modulo NR_REQ.
  - The first asserted req_valid wins.
  - Indices >= NR_REQ are never granted.
- IDLE:
  - If any req_valid is high, req_ready[winner] = 1 in the same cycle (handshake completes that cycle).
  - On that edge: latch winner addr/wen/wdata/wmask into mem_* registers, set grant_idx = winner, set mem_valid = 1, go to ISSUE.
  - If no req_valid is high, stay in IDLE with all req_ready = 0.
- ISSUE:
  - mem_valid = 1; mem_* fields held stable.
  - On mem_ready = 1: clear mem_valid and go to WAIT.
  - req_ready stays 0 throughout.
- WAIT:
  - rsp_valid[grant_idx] = mem_rsp_valid (combinational); rsp_rdata = mem_rdata at all times.
  - On mem_rsp_valid = 1: last_grant <= grant_idx, go to IDLE.
  - Writes also require a mem_rsp_valid ack; rdata is don't-care for writes.
- mem_rsp_valid outside WAIT is ignored: no rsp_valid, no state change. Memory must not respond in the cycle it asserts mem_ready.
- Latency:
  - Accept at cycle T; mem_valid visible T+1; earliest response T+2.
  - Next accept is the cycle after the response.
  - Peak rate is one transaction per 3 cycles.
- Fairness: a continuously requesting requester is granted within NR_REQ transactions.
- Non-granted requesters keep req_valid and their fields held; the arbiter never drops a pending request.
- rst in ISSUE or WAIT abandons the transaction:
  - Returns to reset values.
  - A late mem_rsp_valid after reset is ignored.
  - The next grant goes to requester 0.
- grant_idx holds its value after returning to IDLE until the next accept.

Test Plan:
1. Single read: reset, req_valid[0] = 1, addr 0x8000_0000. Expect req_ready[0] = 1 at T, mem_valid/addr at T+1. Drive mem_ready at T+1 and mem_rsp_valid with 0xDEADBEEF at T+2. Expect rsp_valid[0] = 1 for exactly one cycle, rsp_rdata 0xDEADBEEF, busy low at T+3.
2. Contention, NR_REQ = 2: both req_valid held high, memory always ready with 1-cycle response. Expect grant_idx sequence 0,1,0,1 and rsp_valid pulses alternating.
3. Backpressure: mem_ready low for 5 cycles in ISSUE. Expect mem_valid/mem_addr/mem_wmask stable and all req_ready = 0 for those cycles; completion on the 6th.
4. Write from requester 1: addr 0x8000_0010, wdata 0x1234_5678, wmask 0x3. Expect mem_wen = 1, mem_wmask 0x3, mem_wdata 0x1234_5678. Ack pulses rsp_valid[1] only.
5. Reset in WAIT: assert rst one cycle, then pulse mem_rsp_valid. Expect rsp_valid all 0 and state IDLE. With req 0 and 1 both valid, the first grant goes to requester 0.
6. NR_REQ = 3 fairness: req_valid[0] and [2] high, [1] low. Expect grants 0,2,0,2, never 1; grant_idx never equals 3.
